// File: rtl/bp_me_pkg.sv
// Message types, the command/response struct and the initiator state enum
// shared by the memory-exercise engine and its credit counter.
package bp_me_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 128;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011,
        e_cce_mem_wb    = 4'b0100,
        e_cce_mem_pre   = 4'b0101
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'b000,
        e_mem_msg_size_2  = 3'b001,
        e_mem_msg_size_4  = 3'b010,
        e_mem_msg_size_8  = 3'b011,
        e_mem_msg_size_16 = 3'b100,
        e_mem_msg_size_32 = 3'b101,
        e_mem_msg_size_64 = 3'b110
    } bp_mem_msg_size_e;

    // Same field order and widths as the BlackParrot memory message header
    typedef struct packed {
        logic [15:0]                 payload;
        bp_mem_msg_size_e            size;
        logic [paddr_width_gp-1:0]   addr;
        bp_cce_mem_cmd_type_e        msg_type;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        bp_cce_mem_msg_header_s        header;
    } bp_cce_mem_msg_s;

    typedef enum logic [2:0] {
        e_init_idle   = 3'd0,
        e_init_write  = 3'd1,
        e_init_wdrain = 3'd2,
        e_init_read   = 3'd3,
        e_init_rdrain = 3'd4,
        e_init_done   = 3'd5
    } bp_mem_init_state_e;

    function automatic logic [63:0] bp_pattern(input logic [paddr_width_gp-1:0] addr,
                                               input logic [63:0]               seed);
        return 64'(addr) ^ seed;
    endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter holding the number of commands in flight.
module bsg_counter_up_down #(
    parameter int max_val_p = 4,
    localparam int width_lp = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o
);

    logic [width_lp-1:0] count_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + width_lp'(up_i) - width_lp'(down_i);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_mem_cmd_initiator.sv
// Memory-exercise engine: writes a seeded pattern over a word range, drains,
// reads it back and counts mismatching read responses.
module bp_mem_cmd_initiator
    import bp_me_pkg::*;
#(
    parameter int outstanding_p = 4,
    parameter int cnt_width_p   = 16,
    localparam int msg_width_lp = $bits(bp_cce_mem_msg_s),
    localparam int credit_w_lp  = $clog2(outstanding_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [paddr_width_gp-1:0] base_addr_i,
    input  logic [cnt_width_p-1:0]    num_words_i,
    input  logic [63:0]               seed_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               err_cnt_o,
    output logic [paddr_width_gp-1:0] err_addr_o,
    output logic [msg_width_lp-1:0]   mem_cmd_o,
    output logic                      mem_cmd_v_o,
    input  logic                      mem_cmd_ready_i,
    input  logic [msg_width_lp-1:0]   mem_resp_i,
    input  logic                      mem_resp_v_i,
    output logic                      mem_resp_yumi_o
);

    bp_mem_init_state_e        state_q;
    logic [paddr_width_gp-1:0] base_q;
    logic [paddr_width_gp-1:0] addr_q;
    logic [cnt_width_p-1:0]    num_q;
    logic [cnt_width_p-1:0]    remaining_q;
    logic [63:0]               seed_q;
    logic [15:0]               err_cnt_q;
    logic [paddr_width_gp-1:0] err_addr_q;
    logic                      first_err_q;

    logic [credit_w_lp-1:0]    credit;
    bp_cce_mem_msg_s           cmd_msg;
    bp_cce_mem_msg_s           resp_msg;
    logic                      busy;
    logic                      issuing;
    logic                      cmd_v;
    logic                      cmd_hs;
    logic                      resp_count;
    logic                      credit_down;
    logic                      drain_empty;
    logic                      read_mismatch;

    assign resp_msg = bp_cce_mem_msg_s'(mem_resp_i);

    assign busy    = (state_q == e_init_write) || (state_q == e_init_wdrain)
                  || (state_q == e_init_read)  || (state_q == e_init_rdrain);
    assign issuing = (state_q == e_init_write) || (state_q == e_init_read);

    // Valid depends only on registered state so ready never feeds back into it
    assign cmd_v  = issuing && (remaining_q != '0) && (credit < credit_w_lp'(outstanding_p));
    assign cmd_hs = cmd_v && mem_cmd_ready_i;

    // Responses are always consumed; only those seen while busy affect credits or errors
    assign resp_count  = mem_resp_v_i && busy;
    assign credit_down = resp_count && (credit != '0);
    assign drain_empty = (credit == '0) || ((credit == credit_w_lp'(1)) && credit_down);

    assign read_mismatch = resp_count
                        && (resp_msg.header.msg_type == e_cce_mem_uc_rd)
                        && (resp_msg.data[63:0] != bp_pattern(resp_msg.header.addr, seed_q));

    bsg_counter_up_down #(
        .max_val_p (outstanding_p)
    ) credit_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .up_i      (cmd_hs),
        .down_i    (credit_down),
        .count_o   (credit)
    );

    always_comb begin
        cmd_msg = '0;
        if (cmd_v) begin
            cmd_msg.header.size = e_mem_msg_size_8;
            cmd_msg.header.addr = addr_q;
            if (state_q == e_init_write) begin
                cmd_msg.header.msg_type = e_cce_mem_uc_wr;
                cmd_msg.data[63:0]      = bp_pattern(addr_q, seed_q);
            end else begin
                cmd_msg.header.msg_type = e_cce_mem_uc_rd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_init_idle;
            base_q      <= '0;
            addr_q      <= '0;
            num_q       <= '0;
            remaining_q <= '0;
            seed_q      <= '0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            first_err_q <= 1'b0;
        end else begin
            case (state_q)
                e_init_idle, e_init_done: begin
                    if (start_i) begin
                        base_q      <= base_addr_i;
                        addr_q      <= base_addr_i;
                        num_q       <= num_words_i;
                        remaining_q <= num_words_i;
                        seed_q      <= seed_i;
                        err_cnt_q   <= '0;
                        err_addr_q  <= '0;
                        first_err_q <= 1'b0;
                        state_q     <= (num_words_i != '0) ? e_init_write : e_init_done;
                    end
                end
                e_init_write, e_init_read: begin
                    if (cmd_hs) begin
                        addr_q      <= addr_q + paddr_width_gp'(8);
                        remaining_q <= remaining_q - cnt_width_p'(1);
                        if (remaining_q == cnt_width_p'(1)) begin
                            state_q <= (state_q == e_init_write) ? e_init_wdrain : e_init_rdrain;
                        end
                    end
                end
                e_init_wdrain: begin
                    if (drain_empty) begin
                        addr_q      <= base_q;
                        remaining_q <= num_q;
                        state_q     <= e_init_read;
                    end
                end
                e_init_rdrain: begin
                    if (drain_empty) begin
                        state_q <= e_init_done;
                    end
                end
                default: state_q <= e_init_idle;
            endcase

            if (read_mismatch) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
                if (!first_err_q) begin
                    first_err_q <= 1'b1;
                    err_addr_q  <= resp_msg.header.addr;
                end
            end
        end
    end

    assign busy_o          = busy;
    assign done_o          = (state_q == e_init_done);
    assign err_cnt_o       = err_cnt_q;
    assign err_addr_o      = err_addr_q;
    assign mem_cmd_o       = cmd_msg;
    assign mem_cmd_v_o     = cmd_v;
    assign mem_resp_yumi_o = mem_resp_v_i;

endmodule

// File: tb/tb_bp_mem_cmd_initiator.sv
// Randomized bench: a bp_mem-style responder with random latency plus a
// transaction-level model of what the initiator must issue and report.
module tb_bp_mem_cmd_initiator;
    import bp_me_pkg::*;

    localparam int OP = 4;
    localparam int PW = paddr_width_gp;
    localparam int MW = $bits(bp_cce_mem_msg_s);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_i = 1'b0;
    logic [PW-1:0] base_addr_i = '0;
    logic [15:0]   num_words_i = '0;
    logic [63:0]   seed_i = '0;
    logic          busy_o, done_o, mem_cmd_v_o, mem_resp_yumi_o;
    logic [15:0]   err_cnt_o;
    logic [PW-1:0] err_addr_o;
    logic [MW-1:0] mem_cmd_o;
    logic          mem_cmd_ready_i = 1'b0;
    logic [MW-1:0] mem_resp_i = '0;
    logic          mem_resp_v_i = 1'b0;

    always #5 clk = ~clk;

    bp_mem_cmd_initiator #(.outstanding_p(OP), .cnt_width_p(16)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .num_words_i     (num_words_i),
        .seed_i          (seed_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_cnt_o       (err_cnt_o),
        .err_addr_o      (err_addr_o),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_o (mem_resp_yumi_o)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level model of one run
    bit            runActive = 1'b0;
    logic [PW-1:0] mBase;
    int            mN;
    logic [63:0]   mSeed;
    int            issued, acked;
    int            mErr;
    logic [PW-1:0] mErrAddr;
    bit            mFirst;

    // Responder state
    bp_cce_mem_msg_s rq[$];
    longint          rqDue[$];
    longint          cycle = 0;
    logic [63:0]     mem [logic [PW-1:0]];
    logic [PW-1:0]   corrupt[$];
    int              maxLat = 0;
    bit              randReady = 1'b0;
    bp_cce_mem_msg_s cmdCap[$];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit mDone();
        return runActive && (issued == 2 * mN) && (acked == 2 * mN);
    endfunction

    function automatic bit mBusy();
        return runActive && !mDone();
    endfunction

    function automatic bp_cce_mem_msg_s expCmd(input int k);
        bp_cce_mem_msg_s m;
        int            w;
        logic [PW-1:0] a;
        w = (k < mN) ? k : k - mN;
        a = mBase + (PW'(w) << 3);
        m = '0;
        m.header.size = e_mem_msg_size_8;
        m.header.addr = a;
        if (k < mN) begin
            m.header.msg_type = e_cce_mem_uc_wr;
            m.data[63:0]      = {{(64-PW){1'b0}}, a} ^ mSeed;
        end else begin
            m.header.msg_type = e_cce_mem_uc_rd;
        end
        return m;
    endfunction

    // Compare process and responder, one iteration per clock
    initial begin
        bit              hs, taken, st, busyPre, expV;
        bp_cce_mem_msg_s cmdS, respS, r;
        logic [PW-1:0]   sBase;
        logic [15:0]     sNum;
        logic [63:0]     sSeed;
        longint          due;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            st = 1'b0;
            cmdS = bp_cce_mem_msg_s'(mem_cmd_o);
            if (reset_n) begin
                checkOutput("yumi", 256'(mem_resp_yumi_o), 256'(mem_resp_v_i));
                checkOutput("busy", 256'(busy_o), 256'(mBusy()));
                checkOutput("done", 256'(done_o), 256'(mDone()));
                checkOutput("err_cnt", 256'(err_cnt_o), 256'(mErr));
                checkOutput("err_addr", 256'(err_addr_o), 256'(mErrAddr));
                expV = mBusy() && ((issued - acked) < OP)
                    && ((issued < mN) || ((issued < 2 * mN) && (acked >= mN)));
                checkOutput("cmd_v", 256'(mem_cmd_v_o), 256'(expV));
                if (mem_cmd_v_o && runActive && (issued < 2 * mN)) begin
                    checkOutput("cmd_payload", 256'(mem_cmd_o), 256'(expCmd(issued)));
                end
                hs    = mem_cmd_v_o && mem_cmd_ready_i;
                st    = start_i;
                sBase = base_addr_i;
                sNum  = num_words_i;
                sSeed = seed_i;
            end
            taken = mem_resp_v_i;
            respS = bp_cce_mem_msg_s'(mem_resp_i);

            @(posedge clk);
            #1;
            cycle++;
            if (!reset_n) begin
                runActive = 1'b0;
                hs = 1'b0;
                st = 1'b0;
            end
            busyPre = mBusy();
            if (taken) begin
                if (busyPre) begin
                    acked++;
                    if (respS.header.msg_type == e_cce_mem_uc_rd
                        && respS.data[63:0] != ({{(64-PW){1'b0}}, respS.header.addr} ^ mSeed)) begin
                        if (mErr < 65535) mErr++;
                        if (!mFirst) begin
                            mFirst   = 1'b1;
                            mErrAddr = respS.header.addr;
                        end
                    end
                end
                if (rq.size() > 0) begin
                    void'(rq.pop_front());
                    void'(rqDue.pop_front());
                end
            end
            if (hs) begin
                issued++;
                cmdCap.push_back(cmdS);
                r = '0;
                r.header = cmdS.header;
                if (cmdS.header.msg_type == e_cce_mem_uc_wr) begin
                    mem[cmdS.header.addr] = cmdS.data[63:0];
                end else begin
                    r.data[63:0] = mem.exists(cmdS.header.addr) ? mem[cmdS.header.addr] : 64'd0;
                    foreach (corrupt[i]) begin
                        if (corrupt[i] == cmdS.header.addr) r.data[0] = ~r.data[0];
                    end
                end
                due = cycle + longint'($urandom_range(0, maxLat));
                if (rqDue.size() > 0 && due < rqDue[$]) due = rqDue[$];
                rq.push_back(r);
                rqDue.push_back(due);
            end
            if (st && !busyPre) begin
                runActive = 1'b1;
                mBase     = sBase;
                mN        = int'(sNum);
                mSeed     = sSeed;
                issued    = 0;
                acked     = 0;
                mErr      = 0;
                mErrAddr  = '0;
                mFirst    = 1'b0;
                cmdCap.delete();
            end
            mem_cmd_ready_i = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rq.size() > 0 && rqDue[0] <= cycle) begin
                mem_resp_v_i = 1'b1;
                mem_resp_i   = rq[0];
            end else begin
                mem_resp_v_i = 1'b0;
                mem_resp_i   = '0;
            end
        end
    end

    task automatic applyStimulus(input logic [PW-1:0] base, input logic [15:0] n, input logic [63:0] seed);
        @(posedge clk);
        #2;
        base_addr_i = base;
        num_words_i = n;
        seed_i      = seed;
        start_i     = 1'b1;
        @(posedge clk);
        #2;
        start_i = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_o) break;
        end
        checkOutput("done_within_bound", 256'(i < bound), 256'(1));
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_busy"}, 256'(busy_o), 256'(0));
        checkOutput({tag, "_done"}, 256'(done_o), 256'(0));
        checkOutput({tag, "_err_cnt"}, 256'(err_cnt_o), 256'(0));
        checkOutput({tag, "_err_addr"}, 256'(err_addr_o), 256'(0));
        checkOutput({tag, "_cmd_v"}, 256'(mem_cmd_v_o), 256'(0));
        checkOutput({tag, "_cmd"}, 256'(mem_cmd_o), 256'(0));
    endtask

    initial begin
        #3;
        checkZeroOutputs("reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Basic run with literal pins on the first words
        applyStimulus(40'h80_0000_0000 >> 8, 16'd4, 64'd0);
        waitDone(200);
        checkOutput("t1_cmd_count", 256'(cmdCap.size()), 256'(8));
        if (cmdCap.size() == 8) begin
            checkOutput("t1_wr0_data", 256'(cmdCap[0].data), 256'(64'h8000_0000));
            checkOutput("t1_wr1_data", 256'(cmdCap[1].data), 256'(64'h8000_0008));
            checkOutput("t1_wr3_addr", 256'(cmdCap[3].header.addr), 256'(40'h8000_0018));
            checkOutput("t1_rd0_type", 256'(cmdCap[4].header.msg_type), 256'(e_cce_mem_uc_rd));
        end
        checkOutput("t1_err_cnt", 256'(err_cnt_o), 256'(0));

        // Long latency: credit limit and write drain enforced every cycle
        maxLat = 15;
        applyStimulus(40'h8000_0000, 16'd12, {$urandom, $urandom});
        waitDone(1000);

        // Corrupted reads
        corrupt.push_back(40'h8000_0010);
        corrupt.push_back(40'h8000_0018);
        maxLat = 3;
        applyStimulus(40'h8000_0000, 16'd4, 64'd0);
        waitDone(300);
        checkOutput("t3_err_cnt", 256'(err_cnt_o), 256'(2));
        checkOutput("t3_err_addr", 256'(err_addr_o), 256'(40'h8000_0010));
        corrupt.delete();

        // Zero words: done the cycle after start, nothing issued
        applyStimulus(40'h8000_0000, 16'd0, 64'd5);
        @(negedge clk);
        checkOutput("t4_done", 256'(done_o), 256'(1));
        repeat (3) @(posedge clk);
        checkOutput("t4_no_cmds", 256'(cmdCap.size()), 256'(0));

        // Address wrap at the top of the physical space
        maxLat = 2;
        applyStimulus(40'hFF_FFFF_FFF0, 16'd5, {$urandom, $urandom});
        waitDone(300);

        // Reset in the middle of the write phase
        maxLat = 15;
        applyStimulus(40'h8000_0000, 16'd16, {$urandom, $urandom});
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                @(posedge clk);
                #2;
                if (issued >= 2) break;
            end
            checkOutput("t5_two_writes", 256'(issued >= 2), 256'(1));
        end
        reset_n = 1'b0;
        #1;
        checkZeroOutputs("t5_async");
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        begin
            int k;
            for (k = 0; k < 300; k++) begin
                @(posedge clk);
                if (rq.size() == 0) break;
            end
        end
        checkOutput("t5_late_acks_drained", 256'(rq.size()), 256'(0));
        @(negedge clk);
        checkOutput("t5_idle_err", 256'(err_cnt_o), 256'(0));
        applyStimulus(40'h8000_0100, 16'd6, {$urandom, $urandom});
        waitDone(400);

        // Random ready stalls over 256 words with an ignored mid-run start
        randReady = 1'b1;
        maxLat = 6;
        applyStimulus(40'h9000_0000, 16'd256, {$urandom, $urandom});
        repeat (60) @(posedge clk);
        applyStimulus(40'h1234_5678, 16'd3, 64'hDEAD_BEEF);
        waitDone(8000);
        checkOutput("t6_cmd_count", 256'(cmdCap.size()), 256'(512));
        randReady = 1'b0;

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bp_mem_cmd_initiator.md
# bp_mem_cmd_initiator

Synthesizable memory-exercise engine that drives the command side of the BlackParrot memory interface, the initiator end of the link a `bp_mem` responder serves. On `start_i` it streams uncached 8-byte writes of a deterministic pattern over a word range, drains the write acks, then reads the range back and checks each returned word. It reports an error count and the first failing address. It is used for DRAM bring-up and preload checks in softcore-style benches, standing in for the core at the `bsg_two_fifo` boundary.

## Interface
Parameters:
- `bp_params_p`, `BP_CFG_FLOWVAR`: supplies `paddr_width_p` and `cce_block_width_p`, which size `bp_cce_mem_msg_s`.
- `outstanding_p`, 4: maximum commands in flight, including cycles where responses are still unreturned.
- `cnt_width_p`, 16: width of the word counters.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_n_i`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- `base_addr_i`  in  `paddr_width_p`  first byte address; must be 8-byte aligned. Sampled at start.
- `num_words_i`  in  `cnt_width_p`  number of 64-bit words. Sampled at start.
- `seed_i`  in  64  pattern seed. Sampled at start.
- `busy_o`  out  1  high in WRITE, WDRAIN, READ and RDRAIN.
- `done_o`  out  1  high in DONE; sticky until the next start.
- `err_cnt_o`  out  16  count of read mismatches; saturates at 16'hFFFF.
- `err_addr_o`  out  `paddr_width_p`  address of the first mismatch; 0 if none.
- `mem_cmd_o`  out  `$bits(bp_cce_mem_msg_s)`  command message.
- `mem_cmd_v_o`  out  1  command valid.
- `mem_cmd_ready_i`  in  1  ready-valid acceptance.
- `mem_resp_i`  in  `$bits(bp_cce_mem_msg_s)`  response message.
- `mem_resp_v_i`  in  1  response valid.
- `mem_resp_yumi_o`  out  1  response consumed.

## Operation
- States:
  - IDLE is entered on reset.
  - IDLE or DONE, with `start_i`:
    - go to WRITE if `num_words_i`≠0;
    - else go to DONE the next cycle, with errors cleared.
  - WRITE: after the last write handshake, go to WDRAIN.
  - WDRAIN: when credits return to 0, go to READ.
  - READ: after the last read handshake, go to RDRAIN.
  - RDRAIN: when credits return to 0, go to DONE.
- Start behaviour:
  - Start clears `err_cnt_o`, `err_addr_o` and the first-error flag.
  - Start loads the address counter with `base_addr_i` and the remaining-word counter with `num_words_i`.
  - Start is ignored while busy.
- Command fields:
  - WRITE: `msg_type`=`e_cce_mem_uc_wr`, `size`=`e_mem_msg_size_8`, `addr`=current address, `data[63:0]`=addr zero-extended to 64 bits, XOR `seed_i`; upper data bits 0.
  - READ: `msg_type`=`e_cce_mem_uc_rd`, same size and address; data 0.
  - All other header fields are 0.
- Address counter:
  - Advances by 8 on each handshake.
  - Wraps modulo 2^`paddr_width_p`.
  - Reloads to the base address on the WDRAIN→READ transition.
- Credits:
  - Credit counter range 0..`outstanding_p`.
  - +1 on a command handshake, −1 on a response yumi; both in the same cycle leaves it unchanged.
  - `mem_cmd_v_o` is high only in WRITE or READ, with words remaining and credit < `outstanding_p`.
- Responses:
  - `mem_resp_yumi_o`=`mem_resp_v_i` in every state, including IDLE and DONE, so stale responses are discarded.
  - A response counts only when busy.
  - Read responses (`msg_type` uc_rd): the expected value is `resp.header.addr` XOR the seed. This needs no in-order tracking.
  - On a mismatch, `err_cnt_o` increments, saturating at 16'hFFFF. On the first mismatch only, `err_addr_o` is set to the response address.
  - Write acks only return credit.
- Reset asserted mid-operation:
  - All state is cleared to IDLE immediately.
  - Responses arriving later are dropped.

## Timing
- Reset values: all outputs 0; `mem_cmd_o` all-zero.
- `mem_cmd_o` and `mem_cmd_v_o` are functions of registered state only; no combinational path from `mem_cmd_ready_i`.
- `mem_resp_yumi_o` is combinational from `mem_resp_v_i`.
- Throughput and latency:
  - Up to one command per cycle.
  - The first write is valid the cycle after `start_i`.
  - `done_o` rises the cycle after the final response is yumi'd.
- The command payload is held stable while `mem_cmd_v_o` is high and `mem_cmd_ready_i` is low.

## Structure
- Package `bp_me_pkg` holds `bp_mem_init_state_e`, the six-state enum.
- The message struct comes from `` `declare_bp_me_if ``.
- One sub-module: `bsg_counter_up_down` for the credit counter.

## Test plan
- Base 0x8000_0000, 4 words, seed 0, zero-latency `bp_mem`:
  - 4 uc_wr with data 0x8000_0000, 0x8000_0008, …;
  - then 4 uc_rd;
  - done with `err_cnt_o`=0 and `err_addr_o`=0.
- `outstanding_p`=4 with `bp_mem` at max latency 15: no more than 4 commands ever outstanding; write phase fully drained before the first read.
- Responder corrupts bit 0 of the reads at 0x8000_0010 and 0x8000_0018: `err_cnt_o`=2, `err_addr_o`=0x8000_0010.
- `num_words_i`=0: `done_o` high one cycle after start; no commands issued.
- `reset_n_i` pulsed low after the second write handshake:
  - outputs are 0 asynchronously;
  - late acks are yumi'd and ignored;
  - a new start completes cleanly.
- `mem_cmd_ready_i` toggled randomly for 256 words, with `start_i` also pulsed mid-run: the payload is held stable while stalled and the mid-run start is ignored.
